// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one
// odd-parity frame out on device clock falls and checks the device ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 7800,
  parameter int unsigned START_TIMEOUT_CYCLES = 975000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 130000,
  parameter int unsigned FILTER_LEN           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int unsigned TMAX = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                                 INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned XW = $clog2(XFER_TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t          state, state_n;
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            clk_filt, fall;
  logic [FW-1:0]   filt_cnt;
  logic [TW-1:0]   timer, timer_n, timer_inc;
  logic [XW-1:0]   xfer, xfer_n, xfer_inc;
  logic [3:0]      bit_idx, bit_idx_n;
  logic [9:0]      frame, frame_n;
  logic            data_pull, data_pull_n;
  logic [1:0]      err_code_n;
  logic            xfer_to;

  assign timer_inc = (timer == TW'(TMAX)) ? timer : timer + 1'b1;
  assign xfer_inc  = (xfer == XW'(XFER_TIMEOUT_CYCLES)) ? xfer : xfer + 1'b1;
  assign xfer_to   = (xfer >= XW'(XFER_TIMEOUT_CYCLES - 1));

  // Idle PS/2 lines are high, so synchronizers and filter reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
        fall     <= 1'b0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
        fall     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      xfer      <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      data_pull <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      xfer      <= xfer_n;
      bit_idx   <= bit_idx_n;
      frame     <= frame_n;
      data_pull <= data_pull_n;
      err_code  <= err_code_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    xfer_n      = xfer;
    bit_idx_n   = bit_idx;
    frame_n     = frame;
    data_pull_n = data_pull;
    err_code_n  = err_code;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_busy     = 1'b1;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    case (state)
      S_IDLE: begin
        tx_busy = 1'b0;
        if (tx_start) begin
          frame_n    = {1'b1, ~^tx_data, tx_data};
          err_code_n = '0;
          timer_n    = '0;
          state_n    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer == TW'(INHIBIT_CYCLES - 1)) begin
          ps2_data_oe = 1'b1;
          data_pull_n = 1'b1;
          timer_n     = '0;
          state_n     = S_RTS;
        end else begin
          timer_n = timer_inc;
        end
      end
      S_RTS: begin
        ps2_data_oe = data_pull;
        // Transfer timer starts at 1 so it measures cycles since the fall strobe.
        if (fall) begin
          data_pull_n = ~frame[0];
          bit_idx_n   = 4'd1;
          xfer_n      = XW'(1);
          state_n     = S_SHIFT;
        end else if (timer == TW'(START_TIMEOUT_CYCLES - 1)) begin
          err_code_n = 2'b01;
          state_n    = S_ERR;
        end else begin
          timer_n = timer_inc;
        end
      end
      S_SHIFT: begin
        ps2_data_oe = data_pull;
        if (xfer_to) begin
          err_code_n = 2'b10;
          state_n    = S_ERR;
        end else begin
          xfer_n = xfer_inc;
          if (fall) begin
            data_pull_n = ~frame[bit_idx];
            bit_idx_n   = bit_idx + 1'b1;
            if (bit_idx == 4'd9) state_n = S_ACK;
          end
        end
      end
      S_ACK: begin
        ps2_data_oe = data_pull;
        if (xfer_to) begin
          err_code_n = 2'b10;
          state_n    = S_ERR;
        end else begin
          xfer_n = xfer_inc;
          if (fall) begin
            if (dat_s2) begin
              err_code_n = 2'b11;
              state_n    = S_ERR;
            end else begin
              state_n = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (xfer_to) begin
          err_code_n = 2'b10;
          state_n    = S_ERR;
        end else if (clk_filt && dat_s2) begin
          state_n = S_DONE;
        end else begin
          xfer_n = xfer_inc;
        end
      end
      S_DONE: begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        tx_busy = 1'b0;
        tx_err  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Opposite direction to the existing keyboard receive path.
- Shares the PS2Clk/PS2Data open-drain lines with that receiver. Drives them only through active-high pull-low enables; the top level builds the tristates.
- tx_busy tells the receiver to ignore line activity during a host transmission.

Parameters:
- INHIBIT_CYCLES, 7800, clock-low inhibit time (120 µs at 65 MHz).
- START_TIMEOUT_CYCLES, 975000, maximum wait for the device's first falling clock after the request-to-send (15 ms).
- XFER_TIMEOUT_CYCLES, 130000, maximum time from the first falling clock to the ACK (2 ms).
- FILTER_LEN, 8, consecutive equal samples needed to accept a new filtered ps2_clk level.

Ports:
- clk  in  1  system clock, 65 MHz domain
- rst  in  1  asynchronous reset, active-low
- tx_data  in  8  command byte
- tx_start  in  1  request; accepted only when tx_busy=0
- ps2_clk_in  in  1  PS2Clk pad input
- ps2_data_in  in  1  PS2Data pad input
- ps2_clk_oe  out  1  1 = pull PS2Clk low, 0 = release
- ps2_data_oe  out  1  1 = pull PS2Data low, 0 = release
- tx_busy  out  1  transmission in progress
- tx_done  out  1  one-cycle pulse: byte sent and ACKed
- tx_err  out  1  one-cycle pulse: transmission failed
- err_code  out  2  01 start timeout, 10 transfer timeout, 11 missing ACK; held until next accept

Behaviour:
- Reset (rst=0, async): FSM=IDLE, both oe=0 (lines released), tx_busy=0, tx_done=0, tx_err=0, err_code=00, counters cleared.
- Reset asserted mid-transfer releases both lines immediately; no done or err pulse is issued.
- Input conditioning: ps2_clk_in and ps2_data_in each pass a 2-FF synchronizer.
- Clock is then filtered: the level changes only after FILTER_LEN equal samples.
- fall = filtered clock 1→0, one-cycle strobe.
- Accept: tx_start=1 and state IDLE.
  - Latch frame {stop=1, parity=~^tx_data (odd), tx_data}.
  - tx_busy=1 on the next cycle. tx_start while busy is ignored.
- IDLE: nothing driven.
- INHIBIT:
  - ps2_clk_oe=1 for INHIBIT_CYCLES cycles.
  - ps2_data_oe=1 in the final cycle (start bit = 0).
- RTS:
  - ps2_clk_oe=0, ps2_data_oe stays 1; bit index=0.
  - Wait for fall. Timeout after START_TIMEOUT_CYCLES → ERR, code 01.
- SHIFT:
  - Entered on the first fall. Each fall drives the next frame bit: falls 1..8 = d0..d7 (LSB first), fall 9 = parity, fall 10 = stop.
  - Bit encoding: ps2_data_oe = ~bit, so the stop bit releases the line.
  - Bits change only on fall; no change between falls.
  - Transfer timer starts at the first fall.
- ACK:
  - At fall 11, sample synchronized data. 0 → WAIT_IDLE; 1 → ERR, code 11.
  - Transfer timer reaching XFER_TIMEOUT_CYCLES in SHIFT or ACK → ERR, code 10.
- WAIT_IDLE:
  - Wait until filtered clock=1 and data=1.
  - Then tx_done pulse, tx_busy=0 in the same cycle, state IDLE. Transfer timeout also applies here.
- ERR:
  - Release both lines, tx_err pulse, tx_busy=0, state IDLE.
  - err_code is set in the cycle the pulse fires.
- A new command may be accepted the cycle after done/err.
- Timer widths: ceil(log2(max parameter + 1)). No wrap: every timer saturates at its terminal count.

Test Plan:
- Device BFM. tx_data=0xED, tx_start pulse → clk_oe=1 for 7800 cycles, data_oe=1. BFM then sees bits 1,0,1,1,0,1,1,1, parity 1, stop 1, and ACKs. Required: tx_done after lines idle, tx_busy low the same cycle, err_code=00.
- tx_data=0xF4 → parity bit 0. tx_data=0x00 → parity 1. BFM-decoded byte matches in both cases.
- BFM never clocks → tx_err exactly START_TIMEOUT_CYCLES after clock release, err_code=01, both oe=0.
- BFM clocks but does not pull data at fall 11 → tx_err, err_code=11.
- BFM stops after 5 falls → tx_err at XFER_TIMEOUT_CYCLES from the first fall, err_code=10.
- Assert rst during SHIFT → oe=0 asynchronously, no pulses. tx_start while busy is ignored. A second byte right after tx_done completes correctly.
